// File: rtl/mem_pkg.sv
// Shared types and widths for the CPU block-RAM arbiter.
// Owner encoding tags which requester holds the single in-flight beat.
package mem_pkg;

    localparam int BRAM_ADDR_W = 18;
    localparam int DATA_W      = 32;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of denied fetch cycles; hit is decoded from the registered count.
// Zero latency on hit; no backpressure, inc/clr are sampled every cycle.
module arb_starve_cnt #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic n_reset,
    input  logic inc,
    input  logic clr,
    output logic hit
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != W'(LIMIT))) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit = (cnt_q == W'(LIMIT));

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for the single BRAM port: combinational grant, response 1 cycle later,
// no backpressure on responses. MEM_ARB_ERR_CHECK_EN adds misaligned/out-of-range faulting.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W       = BRAM_ADDR_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [31:0]       d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              bram_en,
    output logic [3:0]        bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_wdata,
    input  logic [DATA_W-1:0] bram_rdata
);

    owner_e      owner_q, owner_d;
    logic        store_q, store_d;
    logic        err_q, err_d;
    logic        starve_hit;
    logic        gnt_if, gnt_d;
    logic        fault_if, fault_d, win_fault, win_store;
    logic [31:0] win_addr;

    arb_starve_cnt #(
        .LIMIT   (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk     (clk),
        .n_reset (n_reset),
        .inc     (if_req & ~gnt_if),
        .clr     (gnt_if | ~if_req),
        .hit     (starve_hit)
    );

`ifdef MEM_ARB_ERR_CHECK_EN
    assign fault_if = (if_addr[1:0] != 2'b00) || ((if_addr >> (ADDR_W + 2)) != 32'd0);
    assign fault_d  = (d_addr[1:0]  != 2'b00) || ((d_addr  >> (ADDR_W + 2)) != 32'd0);
`else
    logic addr_unused;
    assign addr_unused = ^{if_addr, d_addr};
    assign fault_if    = 1'b0;
    assign fault_d     = 1'b0;
`endif

    // Grants are held low while in reset so every output reads 0 then.
    always_comb begin
        gnt_d      = n_reset & d_req & ~(if_req & starve_hit);
        gnt_if     = n_reset & if_req & ~gnt_d;
        win_addr   = gnt_d ? d_addr : if_addr;
        win_fault  = gnt_d ? fault_d : (gnt_if & fault_if);
        win_store  = gnt_d & d_we;

        bram_en    = (gnt_d | gnt_if) & ~win_fault;
        bram_addr  = bram_en ? win_addr[ADDR_W+1:2] : '0;
        bram_we    = (bram_en & win_store) ? d_be : 4'b0000;
        bram_wdata = (bram_en & win_store) ? d_wdata : '0;

        owner_d    = gnt_d ? OWN_D : (gnt_if ? OWN_IF : OWN_NONE);
        store_d    = win_store;
        err_d      = win_fault;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            owner_q <= OWN_NONE;
            store_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            owner_q <= owner_d;
            store_q <= store_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        if_gnt    = gnt_if;
        d_gnt     = gnt_d;
        if_rvalid = (owner_q == OWN_IF);
        d_rvalid  = (owner_q == OWN_D);
        if_err    = if_rvalid & err_q;
        d_err     = d_rvalid & err_q;
        if_rdata  = (if_rvalid & ~err_q) ? bram_rdata : '0;
        d_rdata   = (d_rvalid & ~err_q & ~store_q) ? bram_rdata : '0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural BRAM, arbitration model and
// response scoreboard sampled 1ns after the falling edge.
module tb_mem_arbiter;
    import mem_pkg::*;

    localparam int AW    = 18;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid, if_err;
    logic [31:0] if_rdata;
    logic        d_req, d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr, d_wdata;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rdata;
    logic        bram_en;
    logic [3:0]  bram_we;
    logic [AW-1:0] bram_addr;
    logic [31:0] bram_wdata;
    logic [31:0] bram_rdata;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W       (AW),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .if_err     (if_err),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_be       (d_be),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_gnt      (d_gnt),
        .d_rvalid   (d_rvalid),
        .d_rdata    (d_rdata),
        .d_err      (d_err),
        .bram_en    (bram_en),
        .bram_we    (bram_we),
        .bram_addr  (bram_addr),
        .bram_wdata (bram_wdata),
        .bram_rdata (bram_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural single-port BRAM, one-cycle read latency.
    logic [31:0] mem [64];
    logic [31:0] exp_mem [64];

    always @(posedge clk) begin
        if (bram_en) begin
            bram_rdata <= mem[bram_addr[5:0]];
            for (int b = 0; b < 4; b++) begin
                if (bram_we[b]) mem[bram_addr[5:0]][8*b +: 8] <= bram_wdata[8*b +: 8];
            end
        end
    end

    function automatic bit addr_fault(input logic [31:0] a);
`ifdef MEM_ARB_ERR_CHECK_EN
        return (a[1:0] != 2'b00) || (a >= 32'h0010_0000);
`else
        return (a[31:0] == 32'hFFFF_FFFF) && 1'b0;
`endif
    endfunction

    typedef struct {
        bit          is_d;
        logic [31:0] data;
        bit          err;
    } rsp_t;

    rsp_t sb[$];
    int   sc = 0;

    initial begin
        forever begin
            rsp_t        r;
            bit          eg_d, eg_if, flt, en, st;
            logic [31:0] a, ewd;
            logic [3:0]  ewe;
            @(negedge clk);
            #1;
            if (!n_reset) begin
                sb.delete();
                sc = 0;
                chk("rst_outs", 32'(|{if_gnt, if_rvalid, if_rdata, if_err, d_gnt, d_rvalid, d_rdata,
                                     d_err, bram_en, bram_we, bram_addr, bram_wdata}), 32'd0);
            end else begin
                if (sb.size() > 0) begin
                    r = sb.pop_front();
                    chk("if_rvalid", 32'(if_rvalid), 32'(!r.is_d));
                    chk("d_rvalid", 32'(d_rvalid), 32'(r.is_d));
                    if (r.is_d) begin
                        chk("d_rdata", d_rdata, r.data);
                        chk("d_err", 32'(d_err), 32'(r.err));
                    end else begin
                        chk("if_rdata", if_rdata, r.data);
                        chk("if_err", 32'(if_err), 32'(r.err));
                    end
                end else begin
                    chk("rvalid_idle", 32'({if_rvalid, d_rvalid}), 32'd0);
                end

                eg_d  = d_req && !(if_req && sc == LIMIT);
                eg_if = if_req && !eg_d;
                chk("gnt", 32'({if_gnt, d_gnt}), 32'({eg_if, eg_d}));
                a   = eg_d ? d_addr : if_addr;
                flt = (eg_d || eg_if) && addr_fault(a);
                en  = (eg_d || eg_if) && !flt;
                st  = en && eg_d && d_we;
                ewe = st ? d_be : 4'b0000;
                ewd = st ? d_wdata : 32'd0;
                chk("bram_en", 32'(bram_en), 32'(en));
                chk("bram_addr", 32'(bram_addr), en ? 32'(a[AW+1:2]) : 32'd0);
                chk("bram_we", 32'(bram_we), 32'(ewe));
                chk("bram_wdata", bram_wdata, ewd);

                if (eg_d || eg_if) begin
                    r.is_d = eg_d;
                    r.err  = flt;
                    r.data = (flt || (eg_d && d_we)) ? 32'd0 : exp_mem[a[7:2]];
                    sb.push_back(r);
                    if (st) begin
                        for (int b = 0; b < 4; b++) begin
                            if (d_be[b]) exp_mem[a[7:2]][8*b +: 8] = d_wdata[8*b +: 8];
                        end
                    end
                end

                if (eg_if || !if_req) sc = 0;
                else if (sc < LIMIT) sc++;
            end
        end
    end

    task automatic drive(input bit ir, input logic [31:0] ia, input bit dr, input bit we,
                         input logic [3:0] be, input logic [31:0] da, input logic [31:0] wd);
        @(negedge clk);
        if_req  = ir;
        if_addr = ia;
        d_req   = dr;
        d_we    = we;
        d_be    = be;
        d_addr  = da;
        d_wdata = wd;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 32'd0, 0, 0, 4'd0, 32'd0, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i] = 32'hC0DE_0000 + 32'(i * 32'h0101);
        end
        mem[4] = 32'hE3A0_1005;
        mem[8] = 32'h1122_3344;
        for (int i = 0; i < 64; i++) exp_mem[i] = mem[i];
        bram_rdata = 32'h0;

        // Requests asserted during reset must see nothing granted.
        n_reset = 1'b0;
        if_req = 1'b1; if_addr = 32'h10; d_req = 1'b1; d_we = 1'b0;
        d_be = 4'd0; d_addr = 32'h4; d_wdata = 32'd0;
        repeat (3) @(negedge clk);
        n_reset = 1'b1;
        if_req  = 1'b0;
        d_req   = 1'b0;
        idle(2);

        drive(1, 32'h10, 0, 0, 4'd0, 32'd0, 32'd0);               // single fetch
        idle(1);
        drive(0, 32'd0, 1, 1, 4'b0011, 32'h20, 32'hAABB_CCDD);    // partial store
        drive(0, 32'd0, 1, 0, 4'b0000, 32'h20, 32'd0);            // load back
        idle(1);
        chk("merged_word", exp_mem[8], 32'h1122_CCDD);
        drive(0, 32'd0, 1, 1, 4'b0000, 32'h24, 32'hDEAD_BEEF);    // store with no lanes
        idle(1);
        drive(0, 32'd0, 1, 0, 4'd0, 32'h0, 32'd0);                // back-to-back loads
        drive(0, 32'd0, 1, 0, 4'd0, 32'h4, 32'd0);
        drive(0, 32'd0, 1, 0, 4'd0, 32'h8, 32'd0);
        idle(1);

        for (int i = 0; i < 12; i++) begin                        // contention
            drive(1, 32'h0, 1, 0, 4'd0, 32'hC, 32'd0);
        end
        idle(1);

`ifdef MEM_ARB_ERR_CHECK_EN
        drive(0, 32'd0, 1, 0, 4'd0, 32'h22, 32'd0);
        drive(1, 32'h0010_0000, 0, 0, 4'd0, 32'd0, 32'd0);
`else
        drive(1, 32'h0010_0010, 0, 0, 4'd0, 32'd0, 32'd0);      // high bits ignored
        drive(0, 32'd0, 1, 0, 4'd0, 32'h0000_0012, 32'd0);
`endif
        idle(1);

        // Reset in the response cycle of a load drops that response.
        drive(0, 32'd0, 1, 0, 4'd0, 32'h10, 32'd0);
        @(negedge clk);
        n_reset = 1'b0;
        d_req   = 1'b0;
        #2;
        chk("owner_rst", 32'(dut.owner_q), 32'(OWN_NONE));
        @(negedge clk);
        n_reset = 1'b1;
        idle(1);
        drive(1, 32'h14, 0, 0, 4'd0, 32'd0, 32'd0);
        idle(3);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the CPU's single-ported 32-bit block RAM between the instruction-fetch path and the load/store data path. Each requester raises a request with a byte address and gets a one-cycle grant. The access completes with a one-cycle response strobe on the following clock. Data accesses win by default, and a starvation counter guarantees forward progress for fetch. The block sits between the CPU core and the `bram` instance and is the only driver of the BRAM port.

## Interface
- `ADDR_W`, 18: BRAM word-address width; byte address space is `2^(ADDR_W+2)` bytes.
- `STARVE_LIMIT`, 4: consecutive denied fetch-request cycles after which fetch is forced to win.
- `clk` in 1: clock.
- `n_reset` in 1: reset, asynchronous, active-low.
- `if_req` in 1: fetch request; held until `if_gnt`.
- `if_addr` in 32: fetch byte address.
- `if_gnt` out 1: fetch granted this cycle.
- `if_rvalid` out 1: fetch response valid.
- `if_rdata` out 32: fetch read data, raw BRAM word.
- `if_err` out 1: fetch error, qualified by `if_rvalid`.
- `d_req` in 1: data request; held until `d_gnt`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_be` in 4: store byte enables.
- `d_addr` in 32: data byte address.
- `d_wdata` in 32: store data.
- `d_gnt` out 1: data granted this cycle.
- `d_rvalid` out 1: data response, for loads and stores.
- `d_rdata` out 32: load data; 0 for stores.
- `d_err` out 1: data error, qualified by `d_rvalid`.
- `bram_en` out 1: BRAM access enable.
- `bram_we` out 4: BRAM byte write enables.
- `bram_addr` out ADDR_W: BRAM word address, equal to byte address `>> 2`.
- `bram_wdata` out 32: BRAM write data.
- `bram_rdata` in 32: BRAM read data, valid one cycle after `bram_en`.

## Operation
- Owner register `owner` ∈ {NONE, IF, D} records who holds the in-flight beat. Reset and default value is NONE.
- **Arbitration (combinational, every cycle):**
  - Only `d_req`: grant D.
  - Only `if_req`: grant IF.
  - Both: grant D, unless `starve_cnt == STARVE_LIMIT`, in which case grant IF.
- **Grant cycle:**
  - The winner's `gnt` = 1 and `bram_en` = 1.
  - `bram_addr` = winner address `[ADDR_W+1:2]`.
  - For a D store, `bram_we` = `d_be` and `bram_wdata` = `d_wdata`. Otherwise `bram_we` = 0.
  - `owner` <= winner.
- **Response cycle (the cycle after a grant):**
  - The owner's `rvalid` = 1.
  - The owner's `rdata` = `bram_rdata`, except `d_rdata` = 0 for stores.
  - There is no back-pressure; requesters must accept `rvalid`.
  - A new grant may be issued in the same cycle as a response, giving one beat per cycle.
- **Starvation counter `starve_cnt`** (width `$clog2(STARVE_LIMIT+1)`):
  - Increments each cycle `if_req` is high and `if_gnt` is low, saturating at `STARVE_LIMIT`.
  - Clears on `if_gnt` or on `!if_req`.
- **No request:** `owner` <= NONE, and all BRAM outputs are 0.
- **Store with `d_be` == 0:** still granted and acknowledged; BRAM is enabled with `bram_we` = 0.
- **Reset mid-operation:** the in-flight response is dropped, and no `rvalid` follows reset release.

## Timing
- Grant-to-response latency is exactly 1 cycle.
- `gnt`/BRAM outputs are combinational from `req` and registered state.
- All outputs are 0 during reset. `owner` = NONE and `starve_cnt` = 0.
- Peak throughput is 1 access per cycle. At most one beat is in flight.
- Forced fetch grant happens at most `STARVE_LIMIT+1` cycles after `if_req` rises under continuous `d_req`.

## Configuration
- `MEM_ARB_ERR_CHECK_EN` defined:
  - A request is faulted if it is misaligned (addr`[1:0]` != 0) or out of range (addr `>= 2^(ADDR_W+2)`).
  - A faulted request is granted but does not enable BRAM: `bram_en` = 0 and `bram_we` = 0.
  - Its response has `err` = 1 and `rdata` = 0.
- Undefined: the `err` outputs are tied to 0. Address bits outside `[ADDR_W+1:2]` are silently ignored.

## Structure
- Shared package `mem_pkg`:
  - owner enum `OWN_NONE`/`OWN_IF`/`OWN_D`;
  - `BRAM_ADDR_W` = 18;
  - data width 32.
- Sub-module `arb_starve_cnt`: a saturating counter with inputs `inc`/`clr` and a `hit` output.

## Test plan
- **Single fetch:** with `if_req`, `if_addr`=0x10 and BRAM word 4 = 0xE3A01005, expect `if_gnt` in cycle N, `bram_addr`=4, then `if_rvalid` and `if_rdata`=0xE3A01005 in cycle N+1.
- **Store then load:**
  - `d_we`=1, `d_be`=4'b0011, `d_addr`=0x20, `d_wdata`=0xAABBCCDD over an initial word of 0x11223344: expect `bram_we`=0011 and `d_rvalid` with `d_rdata`=0.
  - A following load of 0x20 then returns 0x1122CCDD.
- **Contention:** with `if_req` and `d_req` both held high continuously, grants go D,D,D,D,IF (`STARVE_LIMIT`=4), and the pattern repeats.
- **Back-to-back:** `d_req` for 3 consecutive loads at 0x0/0x4/0x8 gives grants in cycles N..N+2 and `d_rvalid` in N+1..N+3 with the matching words.
- **Error (macro on):**
  - `d_addr`=0x22 gives `d_gnt`, `bram_en`=0, then `d_err`=1 and `d_rdata`=0.
  - `if_addr`=0x0010_0000 gives `if_err`=1.
- **Reset mid-access:** assert `n_reset` low in the cycle after a grant. Expect no `rvalid`, all outputs 0, and `owner` NONE. After release, the first request is granted normally.
